// File: rtl/fp_pipe_credit_buffer_if.sv
// Handshake bundle between the credit buffer, its argument producer,
// the fixed-latency FP pipeline and the result consumer.
//   arg_vld/arg_rdy            argument handshake (producer -> buffer)
//   pipe_up_valid              issue strobe into the pipeline
//   pipe_down_valid/pipe_res   result strobe and data from the pipeline
//   res_vld/res_rdy/res        AXI-Stream style result output
//   occupancy/in_flight/err    status: stored entries, issued-not-returned, sticky error
// modport slave  : the buffer side
// modport master : the environment side (producer, pipeline, consumer)
interface fp_pipe_credit_buffer_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             arg_vld;
    logic             arg_rdy;
    logic             pipe_up_valid;
    logic             pipe_down_valid;
    logic [WIDTH-1:0] pipe_res;
    logic             res_vld;
    logic             res_rdy;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    occupancy;
    logic [CW-1:0]    in_flight;
    logic             err;

    modport slave (
        input  arg_vld, pipe_down_valid, pipe_res, res_rdy,
        output arg_rdy, pipe_up_valid, res_vld, res, occupancy, in_flight, err
    );

    modport master (
        output arg_vld, pipe_down_valid, pipe_res, res_rdy,
        input  arg_rdy, pipe_up_valid, res_vld, res, occupancy, in_flight, err
    );
endinterface

// File: rtl/fp_pipe_credit_buffer.sv
// Credit-based result buffer around one fixed-latency, non-stallable FP
// pipeline. An argument is issued only when a result FIFO slot is reserved
// for it (occupancy + in_flight < DEPTH), so a returning result always has
// a slot. Results are buffered for an AXI-Stream style consumer.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fp_pipe_credit_buffer_if.slave (handshakes, pipeline strobes, status)
module fp_pipe_credit_buffer #(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned PIPE_LATENCY = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fp_pipe_credit_buffer_if.slave        bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Elaboration-time parameter sanity
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_not_pow2
        $error("fp_pipe_credit_buffer: DEPTH must be a power of two");
    end
    if (DEPTH < PIPE_LATENCY + 2) begin : g_depth_too_small
        $error("fp_pipe_credit_buffer: DEPTH must be >= PIPE_LATENCY+2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    occ_q;
    logic [CW-1:0]    inf_q;
    logic             rdy_q;
    logic             vld_q;
    logic             err_q;

    logic             issue_c;
    logic             pop_c;
    logic             bad_ret_c;
    logic             push_c;
    logic [CW-1:0]    occ_d;
    logic [CW-1:0]    inf_d;
    logic [CW:0]      credit_d;

    // Handshake decode and next counter values
    always_comb begin
        issue_c   = 1'b0;
        pop_c     = 1'b0;
        bad_ret_c = 1'b0;
        push_c    = 1'b0;
        occ_d     = occ_q;
        inf_d     = inf_q;
        credit_d  = '0;

        issue_c   = bus.arg_vld & rdy_q;
        pop_c     = vld_q & bus.res_rdy;
        // A return with nothing outstanding, or into a full FIFO that is not
        // draining this cycle, is dropped and flagged.
        bad_ret_c = bus.pipe_down_valid &
                    ((inf_q == '0) | ((occ_q == CW'(DEPTH)) & ~pop_c));
        push_c    = bus.pipe_down_valid & ~bad_ret_c;

        if (issue_c && !push_c) begin
            inf_d = inf_q + CW'(1);
        end else if (push_c && !issue_c) begin
            inf_d = inf_q - CW'(1);
        end

        if (push_c && !pop_c) begin
            occ_d = occ_q + CW'(1);
        end else if (pop_c && !push_c) begin
            occ_d = occ_q - CW'(1);
        end

        credit_d = (CW+1)'(occ_d) + (CW+1)'(inf_d);
    end

    // Pointers, counters and registered flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
            inf_q  <= '0;
            rdy_q  <= 1'b0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occ_q <= occ_d;
            inf_q <= inf_d;
            rdy_q <= credit_d < (CW+1)'(DEPTH);
            vld_q <= occ_d != '0;
            err_q <= err_q | bad_ret_c;
        end
    end

    // Result storage; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= bus.pipe_res;
        end
    end

    assign bus.arg_rdy       = rdy_q;
    assign bus.pipe_up_valid = issue_c;
    assign bus.res_vld       = vld_q;
    assign bus.res           = mem[rd_ptr];
    assign bus.occupancy     = occ_q;
    assign bus.in_flight     = inf_q;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_fp_pipe_credit_buffer.sv
// Bench for fp_pipe_credit_buffer: a 16-stage delay line stands in for the
// FP pipeline; directed scenarios check reset, streaming, backpressure,
// credit return, random traffic and protocol-error flagging.
module tb_fp_pipe_credit_buffer;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned LAT   = 16;

    logic clk;
    logic rst_n;
    logic inj;
    logic [WIDTH-1:0] arg_data;
    int unsigned arg_cnt;
    int checks;
    int failures;
    logic [WIDTH-1:0] sb [$];

    logic             pipe_v [LAT];
    logic [WIDTH-1:0] pipe_d [LAT];

    fp_pipe_credit_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fp_pipe_credit_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PIPE_LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipeline model: fixed LAT-cycle delay line, flushed by reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= bus.pipe_up_valid;
            pipe_d[0] <= arg_data;
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign bus.pipe_down_valid = pipe_v[LAT-1] | inj;
    assign bus.pipe_res        = inj ? 64'hDEAD_BEEF_0BAD_F00D : pipe_d[LAT-1];

    function automatic logic [WIDTH-1:0] gen(input int unsigned n);
        gen = 64'(n) * 64'h9E37_79B9_7F4A_7C15 + 64'h1;
    endfunction

    // Drive one cycle of inputs, report what the DUT will do at the edge
    task automatic cycle(input logic v, input logic r, output logic issued,
                         output logic popped, output logic [WIDTH-1:0] pdata);
        bus.arg_vld = v;
        bus.res_rdy = r;
        arg_data    = gen(arg_cnt);
        issued      = v & bus.arg_rdy;
        popped      = bus.res_vld & r;
        pdata       = bus.res;
        if (issued) begin
            sb.push_back(arg_data);
            arg_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic iss, pop;
        logic [WIDTH-1:0] pd;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.res_vld !== 1'b0) begin failures++; $display("FAIL reset_init_res_vld got %b exp 0", bus.res_vld); end
        checks++; if (bus.arg_rdy !== 1'b0) begin failures++; $display("FAIL reset_init_arg_rdy got %b exp 0", bus.arg_rdy); end
        checks++; if (bus.occupancy !== '0) begin failures++; $display("FAIL reset_init_occ got %0d exp 0", bus.occupancy); end
        checks++; if (bus.in_flight !== '0) begin failures++; $display("FAIL reset_init_inflight got %0d exp 0", bus.in_flight); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_init_err got %b exp 0", bus.err); end
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, iss, pop, pd);
        checks++; if (bus.arg_rdy !== 1'b1) begin failures++; $display("FAIL reset_release_arg_rdy got %b exp 1", bus.arg_rdy); end
        // Traffic, then reset mid-operation
        repeat (20) cycle(1'b1, 1'b0, iss, pop, pd);
        rst_n = 1'b0;
        repeat (3) cycle(1'b1, 1'b1, iss, pop, pd);
        checks++; if (bus.res_vld !== 1'b0) begin failures++; $display("FAIL reset_mid_res_vld got %b exp 0", bus.res_vld); end
        checks++; if (bus.arg_rdy !== 1'b0) begin failures++; $display("FAIL reset_mid_arg_rdy got %b exp 0", bus.arg_rdy); end
        checks++; if (bus.occupancy !== '0) begin failures++; $display("FAIL reset_mid_occ got %0d exp 0", bus.occupancy); end
        checks++; if (bus.in_flight !== '0) begin failures++; $display("FAIL reset_mid_inflight got %0d exp 0", bus.in_flight); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_mid_err got %b exp 0", bus.err); end
        sb.delete();
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, iss, pop, pd);
        checks++; if (bus.arg_rdy !== 1'b1) begin failures++; $display("FAIL reset_mid_release_arg_rdy got %b exp 1", bus.arg_rdy); end
    endtask

    task automatic test_back_to_back;
        logic iss, pop;
        logic [WIDTH-1:0] pd, exp_d;
        int n_iss, n_pop;
        n_iss = 0;
        n_pop = 0;
        for (int c = 0; c < 1200 && n_pop < 1000; c++) begin
            if (n_iss < 1000) begin
                checks++; if (bus.arg_rdy !== 1'b1) begin failures++; $display("FAIL b2b_arg_rdy cycle %0d got %b exp 1", c, bus.arg_rdy); end
            end
            checks++; if (!(bus.occupancy <= 2)) begin failures++; $display("FAIL b2b_occ cycle %0d got %0d exp <=2", c, bus.occupancy); end
            cycle(n_iss < 1000, 1'b1, iss, pop, pd);
            if (iss) n_iss++;
            if (pop) begin
                n_pop++;
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL b2b_unexpected_pop got %0h exp none", pd); end
                else begin
                    exp_d = sb.pop_front();
                    if (pd !== exp_d) begin failures++; $display("FAIL b2b_data got %0h exp %0h", pd, exp_d); end
                end
            end
        end
        checks++; if (n_iss != 1000) begin failures++; $display("FAIL b2b_issued got %0d exp 1000", n_iss); end
        checks++; if (n_pop != 1000) begin failures++; $display("FAIL b2b_popped got %0d exp 1000", n_pop); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL b2b_err got %b exp 0", bus.err); end
    endtask

    task automatic test_full_backpressure;
        logic iss, pop;
        logic [WIDTH-1:0] pd, head;
        logic have_head;
        int acc;
        acc = 0;
        have_head = 1'b0;
        head = '0;
        for (int c = 0; c < 64; c++) begin
            cycle(1'b1, 1'b0, iss, pop, pd);
            if (iss) acc++;
            if (bus.res_vld === 1'b1) begin
                if (!have_head) begin
                    head = bus.res;
                    have_head = 1'b1;
                end else begin
                    checks++; if (bus.res !== head) begin failures++; $display("FAIL full_res_stable cycle %0d got %0h exp %0h", c, bus.res, head); end
                end
            end
        end
        checks++; if (acc != 32) begin failures++; $display("FAIL full_accepted got %0d exp 32", acc); end
        checks++; if (bus.arg_rdy !== 1'b0) begin failures++; $display("FAIL full_arg_rdy got %b exp 0", bus.arg_rdy); end
        checks++; if (bus.occupancy !== 6'd32) begin failures++; $display("FAIL full_occ got %0d exp 32", bus.occupancy); end
        checks++; if (bus.in_flight !== '0) begin failures++; $display("FAIL full_inflight got %0d exp 0", bus.in_flight); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL full_err got %b exp 0", bus.err); end
        checks++; if (sb.size() == 0 || bus.res !== sb[0]) begin failures++; $display("FAIL full_head got %0h exp first issued", bus.res); end
    endtask

    task automatic test_credit_return;
        logic iss, pop;
        logic [WIDTH-1:0] pd, exp_d;
        exp_d = (sb.size() > 0) ? sb[0] : '0;
        cycle(1'b1, 1'b1, iss, pop, pd);
        checks++; if (iss !== 1'b0) begin failures++; $display("FAIL credit_no_issue_while_full got %b exp 0", iss); end
        checks++; if (pop !== 1'b1 || pd !== exp_d) begin failures++; $display("FAIL credit_pop_data got %0h exp %0h", pd, exp_d); end
        if (pop && sb.size() > 0) void'(sb.pop_front());
        checks++; if (bus.arg_rdy !== 1'b1) begin failures++; $display("FAIL credit_arg_rdy_after_pop got %b exp 1", bus.arg_rdy); end
        checks++; if (bus.occupancy !== 6'd31) begin failures++; $display("FAIL credit_occ got %0d exp 31", bus.occupancy); end
        cycle(1'b1, 1'b0, iss, pop, pd);
        checks++; if (iss !== 1'b1) begin failures++; $display("FAIL credit_one_accept got %b exp 1", iss); end
        checks++; if (bus.arg_rdy !== 1'b0) begin failures++; $display("FAIL credit_arg_rdy_reclosed got %b exp 0", bus.arg_rdy); end
        for (int c = 0; c < 200 && sb.size() > 0; c++) begin
            cycle(1'b0, 1'b1, iss, pop, pd);
            if (pop) begin
                exp_d = sb.pop_front();
                checks++; if (pd !== exp_d) begin failures++; $display("FAIL credit_drain_data got %0h exp %0h", pd, exp_d); end
            end
        end
        checks++; if (sb.size() != 0 || bus.occupancy !== '0 || bus.in_flight !== '0) begin
            failures++; $display("FAIL credit_drain_empty got occ %0d inflight %0d left %0d exp 0", bus.occupancy, bus.in_flight, sb.size());
        end
    endtask

    task automatic test_random;
        logic iss, pop;
        logic [WIDTH-1:0] pd, exp_d;
        int n_iss, n_pop, sum;
        n_iss = 0;
        n_pop = 0;
        for (int c = 0; c < 40000 && n_pop < 5000; c++) begin
            sum = int'(bus.occupancy) + int'(bus.in_flight);
            checks++; if (!(sum <= 32)) begin failures++; $display("FAIL rand_credit_invariant cycle %0d got %0d exp <=32", c, sum); end
            cycle((n_iss < 5000) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1, iss, pop, pd);
            if (iss) n_iss++;
            if (pop) begin
                n_pop++;
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL rand_unexpected_pop got %0h exp none", pd); end
                else begin
                    exp_d = sb.pop_front();
                    if (pd !== exp_d) begin failures++; $display("FAIL rand_data got %0h exp %0h", pd, exp_d); end
                end
            end
        end
        checks++; if (n_iss != 5000) begin failures++; $display("FAIL rand_issued got %0d exp 5000", n_iss); end
        checks++; if (n_pop != 5000) begin failures++; $display("FAIL rand_popped got %0d exp 5000", n_pop); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rand_err got %b exp 0", bus.err); end
    endtask

    task automatic test_protocol_error;
        logic iss, pop;
        logic [WIDTH-1:0] pd;
        inj = 1'b1;
        cycle(1'b0, 1'b0, iss, pop, pd);
        inj = 1'b0;
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL perr_set got %b exp 1", bus.err); end
        checks++; if (bus.occupancy !== '0) begin failures++; $display("FAIL perr_occ got %0d exp 0", bus.occupancy); end
        checks++; if (bus.in_flight !== '0) begin failures++; $display("FAIL perr_inflight got %0d exp 0", bus.in_flight); end
        checks++; if (bus.res_vld !== 1'b0) begin failures++; $display("FAIL perr_res_vld got %b exp 0", bus.res_vld); end
        repeat (5) cycle(1'b0, 1'b1, iss, pop, pd);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL perr_sticky got %b exp 1", bus.err); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL perr_cleared_by_reset got %b exp 0", bus.err); end
        cycle(1'b0, 1'b0, iss, pop, pd);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, iss, pop, pd);
        checks++; if (bus.arg_rdy !== 1'b1 || bus.err !== 1'b0) begin
            failures++; $display("FAIL perr_post_reset got rdy %b err %b exp rdy 1 err 0", bus.arg_rdy, bus.err);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        arg_cnt     = 0;
        inj         = 1'b0;
        arg_data    = '0;
        rst_n       = 1'b0;
        bus.arg_vld = 1'b0;
        bus.res_rdy = 1'b0;
        test_reset();
        test_back_to_back();
        test_full_backpressure();
        test_credit_return();
        test_random();
        test_protocol_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
